rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive grant cycles per holder; 0 disables timeout; legal range 0..255.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  4  per-requester request; bit i held high for as long as requester i wants the shared resource.
REQ-005 Port: grant  output  4  one-hot grant, all-zero when no grant is active.
REQ-006 Port: grant_idx  output  2  binary index of current/last holder.
REQ-007 Port: grant_valid  output  1  high while any grant is active.
REQ-008 Port: timeout  output  1  single-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-009 The FSM SHALL have two states: IDLE (no grant) and GRANT (one holder).
REQ-010 In IDLE, with any eligible request, the arbiter SHALL pick the first eligible requester in order ptr+1, ptr+2, ptr+3, ptr (mod 4), enter GRANT, load grant_idx, set ptr to the winner.
REQ-011 Latency: req sampled at edge N SHALL produce grant at edge N (visible the cycle after req is first high); all outputs registered.
REQ-012 grant SHALL equal the decode of grant_idx when grant_valid=1 and 4'b0000 otherwise; never more than one bit high.
REQ-013 In GRANT, hold_cnt SHALL increment each cycle from 1, saturating at 255.
REQ-014 In GRANT, req[grant_idx]=0 SHALL return to IDLE with grant_valid=0 at the next edge (normal release).
REQ-015 In GRANT, if MAX_HOLD!=0, req[grant_idx]=1 and hold_cnt==MAX_HOLD, the grant SHALL be revoked at the next edge, timeout pulse for exactly that one cycle, state IDLE.
REQ-016 Release and timeout conditions in the same cycle SHALL be treated as normal release; no timeout pulse.
REQ-017 A timed-out requester SHALL set its mask bit; masked requesters are ineligible; mask bit clears when that req bit is sampled low.
REQ-018 After every grant end, at least one cycle with grant_valid=0 SHALL occur before the next grant (guard cycle).
REQ-019 Requests changing on non-holders during GRANT SHALL have no effect until IDLE.
REQ-020 If all requesting inputs are masked, the arbiter SHALL remain in IDLE.
REQ-021 grant_idx SHALL retain its last value while grant_valid=0.

Reset
REQ-022 rst_n low SHALL immediately (asynchronously) force: state IDLE, grant=0, grant_valid=0, grant_idx=0, timeout=0, hold_cnt=0, mask=0, ptr=3 (requester 0 highest priority first).
REQ-023 Reset asserted mid-grant SHALL drop the grant without a timeout pulse; after deassertion arbitration restarts from REQ-022 values.

Structure
REQ-024 Shared package arb_pkg SHALL hold NUM_REQ=4, IDX_W=2, CNT_W=8 and the FSM state encoding (IDLE=0, GRANT=1).
REQ-025 The one-hot grant SHALL be produced by instantiating the existing decoder2to4 on grant_idx, gated by grant_valid; no other sub-module.

Verification
REQ-026 Reset then req=4'b1111 held, holders release after 3 cycles each -> grants in order 0,1,2,3,0 with one guard cycle between.
REQ-027 req=4'b0100 single pulse held 5 cycles -> grant=4'b0100 one cycle after req rises, drops the cycle after req falls, timeout=0.
REQ-028 MAX_HOLD=4, req=4'b0010 held 10 cycles -> grant high 4 cycles, timeout pulse 1 cycle, no regrant to 1 until req[1] goes low then high.
REQ-029 MAX_HOLD=4, holder drops req in the cycle hold_cnt==4 -> normal release, timeout stays 0.
REQ-030 rst_n pulsed low during grant to requester 2 -> grant=0 immediately; after release with req=4'b0101 first grant goes to 0.
REQ-031 Random req traffic 10k cycles -> grant always one-hot or zero, grant==decode(grant_idx) when valid, no requester starved beyond 3 other grants.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// rr_pick returns the first eligible requester searched from ptr+1 around to ptr.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] elig,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p.found = 1'b0;
        p.idx   = ptr;
        // Walk from lowest to highest priority so the last hit wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ptr + IDX_W'(k);
            if (elig[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/decoder2to4.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module decoder2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] dec
);

    always_comb begin
        dec = 4'b0000;
        if (en) begin
            dec[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with per-holder hold limit and masking
// of timed-out requesters until they drop their request.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               timeout,
    output arb_state_e         dbg_state
);

    // Handshake: a requester raises req[i] and holds it; grant[i] appears one
    // cycle later and stays while req[i] is held. Dropping req[i] ends the grant
    // at the next edge; a hold limit hit ends it with a one-cycle timeout pulse.

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic               timeout_q, timeout_d;
    pick_t              pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        pick      = rr_pick(req & ~mask_q, ptr_q);
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        // A mask bit survives only while its request stays high.
        mask_d    = mask_q & req;
        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    state_d = GRANT;
                    idx_d   = pick.idx;
                    ptr_d   = pick.idx;
                    cnt_d   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (TIMEOUT_EN && (cnt_q == HOLD_LIMIT)) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    timeout_d     = 1'b1;
                    mask_d[idx_q] = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_valid = (state_q == GRANT);
        grant_idx   = idx_q;
        timeout     = timeout_q;
        dbg_state   = state_q;
    end

    decoder2to4 u_dec (
        .sel (grant_idx),
        .en  (grant_valid),
        .dec (grant)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: two instances (hold limit 4 and default 16)
// share one request stream and are compared cycle by cycle against a reference model.
module tb_rr_arbiter4;
    import arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] grant4, grant16;
    logic [1:0] grant_idx4, grant_idx16;
    logic       grant_valid4, grant_valid16;
    logic       timeout4, timeout16;
    arb_state_e dbg4, dbg16;

    rr_arbiter4 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant4), .grant_idx(grant_idx4),
        .grant_valid(grant_valid4), .timeout(timeout4), .dbg_state(dbg4)
    );

    rr_arbiter4 dut16 (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant16), .grant_idx(grant_idx16),
        .grant_valid(grant_valid16), .timeout(timeout16), .dbg_state(dbg16)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters and scoreboard ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q4[$];
    logic [8:0] exp_q16[$];
    logic [3:0] req_at_edge = 4'b0000;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Holder is -1 when nobody owns the resource; counts are plain integers.
    int       m_holder[2];
    int       m_last[2];
    int       m_cnt[2];
    int       m_ptr[2];
    bit [3:0] m_mask[2];
    bit       m_to[2];
    int       m_limit[2] = '{4, 16};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_holder[k] = -1;
            m_last[k]   = 0;
            m_cnt[k]    = 0;
            m_ptr[k]    = 3;
            m_mask[k]   = 4'b0000;
            m_to[k]     = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] r);
        int h;
        h = m_holder[k];
        m_to[k] = 1'b0;
        if (h >= 0) begin
            if (!r[h]) begin
                m_holder[k] = -1;
            end else if (m_limit[k] != 0 && m_cnt[k] == m_limit[k]) begin
                m_holder[k]  = -1;
                m_to[k]      = 1'b1;
                m_mask[k][h] = 1'b1;
            end else begin
                m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
            end
        end else begin
            for (int off = 1; off <= 4; off++) begin
                int c;
                c = (m_ptr[k] + off) % 4;
                if (r[c] && !m_mask[k][c]) begin
                    m_holder[k] = c;
                    m_last[k]   = c;
                    m_ptr[k]    = c;
                    m_cnt[k]    = 1;
                    break;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!r[i]) m_mask[k][i] = 1'b0;
        end
    endtask

    function automatic logic [8:0] exp_word(input int k);
        logic       v;
        logic [3:0] g;
        logic [1:0] li;
        v  = (m_holder[k] >= 0);
        g  = v ? (4'b0001 << m_holder[k]) : 4'b0000;
        li = m_last[k][1:0];
        return {v, m_to[k], v, li, g};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic edge_update(input logic [3:0] r);
        @(posedge clk);
        req_at_edge = r;
        model_step(0, r);
        model_step(1, r);
        exp_q4.push_back(exp_word(0));
        exp_q16.push_back(exp_word(1));
    endtask

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        edge_update(r);
    endtask

    task automatic release_reset(input logic [3:0] r);
        @(negedge clk);
        req   = r;
        rst_n = 1'b1;
        edge_update(r);
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int         g4[4];
    int         g16[4];
    int         to4 = 0;
    int         to16 = 0;
    int         obs_order[$];
    int         wait_cnt[4];
    logic [3:0] obs_mask = 4'b0000;
    logic       prev_valid = 1'b0;
    logic [8:0] e4, e16;
    logic [3:0] elig;
    int         worst;

    task automatic clr_stats();
        for (int i = 0; i < 4; i++) begin
            g4[i]  = 0;
            g16[i] = 0;
        end
        to4  = 0;
        to16 = 0;
        obs_order.delete();
    endtask

    task automatic clr_obs();
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        obs_mask   = 4'b0000;
        prev_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q4.size() > 0) begin
            e4 = exp_q4.pop_front();
            check("out4", int'({dbg4 == GRANT, timeout4, grant_valid4, grant_idx4, grant4}), int'(e4));
            if (grant_valid4) g4[grant_idx4]++;
            if (timeout4) to4++;
            // Fairness: an eligible requester may lose at most three arbitrations in a row.
            elig = req_at_edge & ~obs_mask;
            if (grant_valid4 && !prev_valid) begin
                obs_order.push_back(int'(grant_idx4));
                worst = 0;
                for (int i = 0; i < 4; i++) begin
                    if (i == int'(grant_idx4)) wait_cnt[i] = 0;
                    else if (elig[i]) wait_cnt[i]++;
                    if (wait_cnt[i] > worst) worst = wait_cnt[i];
                end
                check("starve_le3", int'(worst <= 3), 1);
            end
            for (int i = 0; i < 4; i++) begin
                if (!req_at_edge[i]) wait_cnt[i] = 0;
            end
            obs_mask = obs_mask & req_at_edge;
            if (timeout4) obs_mask[grant_idx4] = 1'b1;
            prev_valid = grant_valid4;
        end
        if (exp_q16.size() > 0) begin
            e16 = exp_q16.pop_front();
            check("out16", int'({dbg16 == GRANT, timeout16, grant_valid16, grant_idx16, grant16}), int'(e16));
            if (grant_valid16) g16[grant_idx16]++;
            if (timeout16) to16++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] r;
        model_reset();
        clr_stats();
        clr_obs();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_grant4", int'(grant4), 0);
        check("rst_valid4", int'(grant_valid4), 0);
        check("rst_idx4", int'(grant_idx4), 0);
        check("rst_timeout4", int'(timeout4), 0);
        check("rst_state16", int'(dbg16 == GRANT), 0);
        release_reset(4'b0000);

        // All request, each holder releases after 3 cycles: order 0,1,2,3,0
        clr_stats();
        for (int n = 0; n < 20; n++) begin
            r = 4'b1111;
            if (m_holder[0] >= 0 && m_cnt[0] == 3) r[m_holder[0]] = 1'b0;
            step(r);
        end
        step(4'b0000);
        step(4'b0000);
        drain();
        check("rr_order_len", obs_order.size(), 5);
        for (int i = 0; i < 5 && i < obs_order.size(); i++) begin
            check("rr_order", obs_order[i], i % 4);
        end

        // Single request held 5 cycles on the default-limit instance
        clr_stats();
        repeat (5) step(4'b0100);
        repeat (3) step(4'b0000);
        drain();
        check("hold5_cycles16", g16[2], 5);
        check("hold5_timeout16", to16, 0);

        // Hold limit 4 with request held 10 cycles
        clr_stats();
        repeat (10) step(4'b0010);
        repeat (2) step(4'b0000);
        drain();
        check("tmo_cycles4", g4[1], 4);
        check("tmo_pulses4", to4, 1);
        check("tmo_cycles16", g16[1], 10);
        clr_stats();
        repeat (2) step(4'b0010);
        repeat (2) step(4'b0000);
        drain();
        check("regrant_after_low4", g4[1], 2);

        // Holder drops request exactly when the count hits the limit
        clr_stats();
        repeat (4) step(4'b0001);
        repeat (2) step(4'b0000);
        drain();
        check("release_at_limit_cycles4", g4[0], 4);
        check("release_at_limit_tmo4", to4, 0);

        // Asynchronous reset during a grant to requester 2
        repeat (3) step(4'b0100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_grant4", int'(grant4), 0);
        check("async_valid16", int'(grant_valid16), 0);
        check("async_timeout4", int'(timeout4), 0);
        check("async_idx16", int'(grant_idx16), 0);
        model_reset();
        clr_obs();
        clr_stats();
        req = 4'b0101;
        repeat (2) @(posedge clk);
        release_reset(4'b0101);
        repeat (2) step(4'b0101);
        repeat (2) step(4'b0000);
        drain();
        check("post_reset_first_len", int'(obs_order.size() >= 1), 1);
        if (obs_order.size() >= 1) check("post_reset_first", obs_order[0], 0);

        // Random traffic
        r = 4'b0000;
        for (int n = 0; n < 10000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            end
            step(r);
        end
        repeat (2) step(4'b0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
